// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing types, standard mode constants and helpers.
// Provides vga_timing_t, CW_DEF, MODE_* constants, h_total() and v_total().
package vga_pkg;

  localparam int CW_DEF = 11;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_timing_t;

  localparam vga_timing_t MODE_640X480 =
    '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam vga_timing_t MODE_800X600 =
    '{800, 40, 128, 88, 600, 1, 4, 23};
  localparam vga_timing_t MODE_1024X768 =
    '{1024, 24, 136, 160, 768, 3, 6, 29};

  function automatic int h_total(vga_timing_t m);
    return m.h_active + m.h_fp + m.h_sync + m.h_bp;
  endfunction

  function automatic int v_total(vga_timing_t m);
    return m.v_active + m.v_fp + m.v_sync + m.v_bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enable-gated W-bit, D-stage shift register.
// Ports: clk, rst_n (async clear to RST), en, d in; q (last stage) out.
module vga_delay_line #(
  parameter int           W   = 3,
  parameter int           D   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) stg[i] <= RST;
    end else if (en) begin
      stg[0] <= d;
      for (int i = 1; i < D; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[D-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with pixel enable.
// Ports: clk, rst_n, pix_en in; x, y, hsync, vsync, de, vga_blank,
// vga_sync, line_start, frame_start out.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int H_ACTIVE = MODE_640X480.h_active,
  parameter int H_FP     = MODE_640X480.h_fp,
  parameter int H_SYNC   = MODE_640X480.h_sync,
  parameter int H_BP     = MODE_640X480.h_bp,
  parameter int V_ACTIVE = MODE_640X480.v_active,
  parameter int V_FP     = MODE_640X480.v_fp,
  parameter int V_SYNC   = MODE_640X480.v_sync,
  parameter int V_BP     = MODE_640X480.v_bp,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int LAT      = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          vga_blank,
  output logic          vga_sync,
  output logic          line_start,
  output logic          frame_start
);

  localparam vga_timing_t MODE = '{
    H_ACTIVE, H_FP, H_SYNC, H_BP,
    V_ACTIVE, V_FP, V_SYNC, V_BP
  };
  localparam int H_TOTAL = h_total(MODE);
  localparam int V_TOTAL = v_total(MODE);

  if (H_TOTAL > (1 << CW)) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL exceeds 2**CW");
  end
  if (V_TOTAL > (1 << CW)) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL exceeds 2**CW");
  end
  if (LAT < 1 || LAT > 8) begin : g_bad_lat
    $error("vga_timing_gen: LAT outside 1..8");
  end

  localparam logic [CW-1:0] X_MAX  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_MAX  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] x_q, y_q;
  logic          x_wrap, y_wrap;
  logic          ls_q, fs_q;

  assign x_wrap = (x_q == X_MAX);
  assign y_wrap = (y_q == Y_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      // strobes follow the edge that wrapped, so they drop on idle cycles
      ls_q <= pix_en & x_wrap;
      fs_q <= pix_en & x_wrap & y_wrap;
      if (pix_en) begin
        x_q <= x_wrap ? '0 : x_q + 1'b1;
        if (x_wrap) y_q <= y_wrap ? '0 : y_q + 1'b1;
      end
    end
  end

  logic hs_raw, vs_raw, de_raw;
  logic [2:0] dly;

  assign hs_raw = (x_q >= HS_BEG) && (x_q <= HS_LST);
  assign vs_raw = (y_q >= VS_BEG) && (y_q <= VS_LST);
  assign de_raw = (x_q < X_ACT) && (y_q < Y_ACT);

  // stages hold active-high raw flags; polarity is applied at the output
  vga_delay_line #(
    .W   (3),
    .D   (LAT),
    .RST (3'b000)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .d     ({hs_raw, vs_raw, de_raw}),
    .q     (dly)
  );

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = (H_POL != 0) ? dly[2] : ~dly[2];
  assign vsync       = (V_POL != 0) ? dly[1] : ~dly[1];
  assign de          = dly[0];
  assign vga_blank   = dly[0];
  assign vga_sync    = 1'b0;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
